// File: rtl/bus_demux4_if.sv
// bus_demux4_if: initiator-side request/response bus plus the
// four-target fan-out bundle carried by bus_demux4.
interface bus_demux4_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [AW-1:0]     req_addr;
  logic              req_we;
  logic [DW-1:0]     req_wdata;
  logic [DW/8-1:0]   req_be;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_rdata;

  logic [3:0]        t_req_valid;
  logic [3:0]        t_req_ready;
  logic [AW-1:0]     t_req_addr;
  logic              t_req_we;
  logic [DW-1:0]     t_req_wdata;
  logic [DW/8-1:0]   t_req_be;
  logic [3:0]        t_rsp_valid;
  logic [3:0]        t_rsp_ready;
  logic [4*DW-1:0]   t_rsp_rdata;

  modport slave (
    input  req_valid, req_addr, req_we,
    input  req_wdata, req_be,
    input  t_req_ready, t_rsp_valid,
    input  t_rsp_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output t_req_valid, t_req_addr,
    output t_req_we, t_req_wdata, t_req_be,
    output t_rsp_ready
  );

  modport master (
    output req_valid, req_addr, req_we,
    output req_wdata, req_be,
    output t_req_ready, t_rsp_valid,
    output t_rsp_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  t_req_valid, t_req_addr,
    input  t_req_we, t_req_wdata, t_req_be,
    input  t_rsp_ready
  );
endinterface

// File: rtl/bus_demux4.sv
// bus_demux4: routes one request stream to four targets and returns
// their responses in request order using a FIFO of target IDs.
module bus_demux4 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SEL_LSB = 28,
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  bus_demux4_if.slave bus,
  output logic        idle
);
  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUT);

  logic [1:0]    r_ids [MAX_OUT];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic [AW-1:0] w_addr;
  logic [1:0]    w_sel;
  logic [1:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_ready;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic [3:0]    w_t_req_valid;
  logic [3:0]    w_t_rsp_ready;

  assign w_addr = bus.req_addr;
  assign w_sel  = w_addr[SEL_LSB+1:SEL_LSB];
  assign w_head = r_ids[r_rptr];

  // reset forces full and empty so every handshake output is low
  assign w_full  = !rst_n || (r_count == FULL_CNT);
  assign w_empty = !rst_n || (r_count == '0);

  assign w_ready = bus.t_req_ready[w_sel] && !w_full;
  assign w_rsp   = !w_empty && bus.t_rsp_valid[w_head];
  assign w_push  = bus.req_valid && w_ready;
  assign w_pop   = w_rsp;

  always_comb begin
    w_t_req_valid = '0;
    if (bus.req_valid && !w_full)
      w_t_req_valid[w_sel] = 1'b1;
  end

  always_comb begin
    w_t_rsp_ready = '0;
    if (!w_empty)
      w_t_rsp_ready[w_head] = 1'b1;
  end

  assign bus.req_ready   = w_ready;
  assign bus.t_req_valid = w_t_req_valid;
  assign bus.t_req_addr  = w_addr;
  assign bus.t_req_we    = bus.req_we;
  assign bus.t_req_wdata = bus.req_wdata;
  assign bus.t_req_be    = bus.req_be;

  assign bus.t_rsp_ready = w_t_rsp_ready;
  assign bus.rsp_valid   = w_rsp;
  assign bus.rsp_rdata   =
    bus.t_rsp_rdata[int'(w_head)*DW +: DW];

  assign idle = w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUT; i++)
        r_ids[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_ids[r_wptr] <= w_sel;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_demux4.sv
// tb_bus_demux4: directed scenarios checked against an in-order
// queue model of outstanding target IDs every cycle.
module tb_bus_demux4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic idle;

  int n_tests = 0;
  int n_fail  = 0;

  bus_demux4_if #(.AW(32), .DW(32)) bus ();

  bus_demux4 #(
    .AW(32), .DW(32), .SEL_LSB(28), .MAX_OUT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .idle (idle)
  );

  always #5 clk = ~clk;

  logic [1:0]  mq [$];
  logic [31:0] tdata [4];
  logic        m_push = 1'b0;
  logic        m_pop  = 1'b0;
  logic [1:0]  m_sel  = 2'd0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [1:0] s;
    logic [1:0] h;
    logic       full;
    logic       empty;
    logic [3:0] etv;
    logic [3:0] etr;
    logic       erdy;
    logic       ersp;
    s = bus.req_addr[29:28];
    if (!rst_n) begin
      chk("rst_idle", 32'(idle), 32'd1);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_t_req_valid", 32'(bus.t_req_valid), 32'd0);
      chk("rst_t_rsp_ready", 32'(bus.t_rsp_ready), 32'd0);
      m_push = 1'b0;
      m_pop  = 1'b0;
    end else begin
      full  = (mq.size() == 4);
      empty = (mq.size() == 0);
      h     = empty ? 2'd0 : mq[0];
      etv   = (bus.req_valid && !full) ? 4'(1 << s) : 4'd0;
      erdy  = bus.t_req_ready[s] && !full;
      etr   = empty ? 4'd0 : 4'(1 << h);
      ersp  = !empty && bus.t_rsp_valid[h];
      chk("idle", 32'(idle), 32'(empty));
      chk("t_req_valid", 32'(bus.t_req_valid), 32'(etv));
      chk("req_ready", 32'(bus.req_ready), 32'(erdy));
      chk("t_rsp_ready", 32'(bus.t_rsp_ready), 32'(etr));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(ersp));
      if (ersp)
        chk("rsp_rdata", bus.rsp_rdata, tdata[h]);
      chk("t_req_addr", bus.t_req_addr, bus.req_addr);
      chk("t_req_wdata", bus.t_req_wdata, bus.req_wdata);
      chk("t_req_be", 32'(bus.t_req_be), 32'(bus.req_be));
      chk("t_req_we", 32'(bus.t_req_we), 32'(bus.req_we));
      m_push = bus.req_valid && erdy;
      m_sel  = s;
      m_pop  = ersp;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      if (m_pop)
        void'(mq.pop_front());
      if (m_push)
        mq.push_back(m_sel);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] t,
                     input logic [31:0] off);
    bus.req_valid = 1'b1;
    bus.req_addr  = {2'b00, t, 28'h0} + off;
    bus.req_we    = off[2];
    bus.req_wdata = 32'hA5A5_0000 + off;
    bus.req_be    = off[3:0] | 4'h1;
  endtask

  task automatic clear_req();
    bus.req_valid = 1'b0;
  endtask

  task automatic rsp_on(input logic [1:0] t,
                        input logic [31:0] d);
    tdata[t] = d;
    bus.t_rsp_valid[t] = 1'b1;
    bus.t_rsp_rdata[int'(t)*32 +: 32] = d;
  endtask

  task automatic rsp_off();
    bus.t_rsp_valid = 4'd0;
  endtask

  initial begin : stim
    logic [1:0] order [4];
    for (int i = 0; i < 4; i++)
      tdata[i] = 32'd0;
    bus.req_valid   = 1'b0;
    bus.req_addr    = 32'd0;
    bus.req_we      = 1'b0;
    bus.req_wdata   = 32'd0;
    bus.req_be      = 4'd0;
    bus.t_req_ready = 4'd0;
    bus.t_rsp_valid = 4'd0;
    bus.t_rsp_rdata = '0;

    // reset holds every handshake low even with inputs active
    #2;
    bus.req_valid   = 1'b1;
    bus.t_req_ready = 4'b1111;
    #1;
    chk("hold_rst_idle", 32'(idle), 32'd1);
    chk("hold_rst_ready", 32'(bus.req_ready), 32'd0);
    chk("hold_rst_tv", 32'(bus.t_req_valid), 32'd0);
    bus.req_valid   = 1'b0;
    bus.t_req_ready = 4'd0;
    tick();
    tick();
    rst_n = 1'b1;

    // single read to target 2
    req(2'd2, 32'h10);
    bus.t_req_ready = 4'b0100;
    #1;
    chk("s1_addr", bus.req_addr, 32'h2000_0010);
    chk("s1_ready", 32'(bus.req_ready), 32'd1);
    chk("s1_tv", 32'(bus.t_req_valid), 32'b0100);
    tick();
    clear_req();
    bus.t_req_ready = 4'd0;
    #1;
    chk("s1_busy", 32'(idle), 32'd0);
    tick();
    rsp_on(2'd2, 32'hCAFE_F00D);
    #1;
    chk("s1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("s1_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    chk("s1_trr", 32'(bus.t_rsp_ready), 32'b0100);
    tick();
    rsp_off();
    #1;
    chk("s1_idle", 32'(idle), 32'd1);

    // fill to MAX_OUT, then pop while a fifth request waits
    bus.t_req_ready = 4'b1111;
    order = '{2'd0, 2'd1, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      req(order[i], 32'(i * 16));
      tick();
    end
    req(2'd2, 32'h20);
    #1;
    chk("s2_busy", 32'(idle), 32'd0);
    chk("s2_full_ready", 32'(bus.req_ready), 32'd0);
    chk("s2_full_tv", 32'(bus.t_req_valid), 32'd0);
    tick();
    chk("s2_still_held", 32'(bus.req_ready), 32'd0);
    rsp_on(2'd0, 32'hD000_0000);
    #1;
    chk("s4_pop_valid", 32'(bus.rsp_valid), 32'd1);
    chk("s4_pop_rdata", bus.rsp_rdata, 32'hD000_0000);
    chk("s4_push_refused", 32'(bus.req_ready), 32'd0);
    tick();
    rsp_off();
    #1;
    chk("s4_accept_next", 32'(bus.req_ready), 32'd1);
    chk("s4_tv", 32'(bus.t_req_valid), 32'b0100);
    tick();
    clear_req();
    order = '{2'd1, 2'd3, 2'd0, 2'd2};
    for (int i = 0; i < 4; i++) begin
      rsp_on(order[i], 32'hD000_0010 + 32'(i));
      #1;
      chk("s2_drain", bus.rsp_rdata, 32'hD000_0010 + 32'(i));
      tick();
      rsp_off();
    end
    #1;
    chk("s2_idle", 32'(idle), 32'd1);

    // target 3 answers early but must wait behind target 1
    req(2'd1, 32'h0);
    tick();
    req(2'd3, 32'h4);
    tick();
    clear_req();
    rsp_on(2'd3, 32'h3333_3333);
    #1;
    chk("s3_trr_head1", 32'(bus.t_rsp_ready), 32'b0010);
    chk("s3_stall", 32'(bus.rsp_valid), 32'd0);
    tick();
    rsp_on(2'd1, 32'h1111_1111);
    #1;
    chk("s3_first", bus.rsp_rdata, 32'h1111_1111);
    tick();
    bus.t_rsp_valid[1] = 1'b0;
    #1;
    chk("s3_second_valid", 32'(bus.rsp_valid), 32'd1);
    chk("s3_second", bus.rsp_rdata, 32'h3333_3333);
    chk("s3_trr_head3", 32'(bus.t_rsp_ready), 32'b1000);
    tick();
    rsp_off();
    #1;
    chk("s3_idle", 32'(idle), 32'd1);

    // ten request/response pairs wrap the pointers twice
    for (int i = 0; i < 10; i++) begin
      req(2'(i % 4), 32'(i * 8));
      tick();
      clear_req();
      rsp_on(2'(i % 4), 32'h5000_0000 + 32'(i));
      #1;
      chk("s5_wrap", bus.rsp_rdata, 32'h5000_0000 + 32'(i));
      tick();
      rsp_off();
    end
    #1;
    chk("s5_idle", 32'(idle), 32'd1);

    // async reset with three requests outstanding
    req(2'd0, 32'h0);
    tick();
    req(2'd1, 32'h0);
    tick();
    req(2'd2, 32'h0);
    tick();
    req(2'd3, 32'h0);
    rsp_on(2'd0, 32'h7777_0000);
    #1;
    chk("s6_pre_rsp", 32'(bus.rsp_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("s6_idle", 32'(idle), 32'd1);
    chk("s6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("s6_ready", 32'(bus.req_ready), 32'd0);
    chk("s6_tv", 32'(bus.t_req_valid), 32'd0);
    tick();
    rsp_off();
    clear_req();
    rst_n = 1'b1;
    req(2'd0, 32'h40);
    #1;
    chk("s6_new_ready", 32'(bus.req_ready), 32'd1);
    tick();
    clear_req();
    rsp_on(2'd0, 32'h0BAD_BEEF);
    #1;
    chk("s6_new_rdata", bus.rsp_rdata, 32'h0BAD_BEEF);
    tick();
    rsp_off();
    #1;
    chk("s6_idle_end", 32'(idle), 32'd1);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
